serial_pattern_gen: RTL and testbench

//  Serial bit-pattern transmitter: drives the one-bit x input of the sequence detector.

---
 rtl/serial_pattern_gen_if.sv | 23 ++
 rtl/serial_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_serial_pattern_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_gen_if.sv
// Handshake and serial-output bundle for serial_pattern_gen.
// The master side drives start/pattern/repeat_en; the slave side is the generator.
interface serial_pattern_gen_if #(
    parameter int PATTERN_W = 8
);
    logic                 start;
    logic [PATTERN_W-1:0] pattern;
    logic                 repeat_en;
    logic                 x_out;
    logic                 bit_tick;
    logic                 busy;
    logic                 done;

    modport master (
        output start, pattern, repeat_en,
        input  x_out, bit_tick, busy, done
    );

    modport slave (
        input  start, pattern, repeat_en,
        output x_out, bit_tick, busy, done
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial MSB-first pattern transmitter with idle-high gap and optional repeat.
// Define SEQGEN_SEG_EN to add the registered active-low 7-segment mirror of x_out.
module serial_pattern_gen #(
    parameter int PATTERN_W = 8,
    parameter int DIV       = 20000000,
    parameter int GAP_TICKS = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef SEQGEN_SEG_EN
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
`endif
    serial_pattern_gen_if.slave bus
);
    localparam int CW   = $clog2(DIV + 1);
    localparam int IMAX = (PATTERN_W > GAP_TICKS) ? PATTERN_W : GAP_TICKS;
    localparam int IW   = (IMAX > 1) ? $clog2(IMAX) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] BIT_LAST = IW'(PATTERN_W - 1);
    localparam logic [IW-1:0] GAP_LAST =
        (GAP_TICKS > 0) ? IW'(GAP_TICKS - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [PATTERN_W-1:0] shreg, shreg_n;
    logic [PATTERN_W-1:0] pat_q, pat_n;
    logic [PATTERN_W-1:0] shifted;
    logic                 x_q, x_n;
    logic                 tick_q, tick_n;
    logic                 done_q, done_n;
    logic                 eof;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            pat_q  <= '0;
            x_q    <= 1'b1;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shreg  <= shreg_n;
            pat_q  <= pat_n;
            x_q    <= x_n;
            tick_q <= tick_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        pat_n   = pat_q;
        x_n     = x_q;
        tick_n  = 1'b0;
        done_n  = 1'b0;
        eof     = 1'b0;
        shifted = shreg << 1;

        unique case (state)
            S_IDLE: begin
                x_n = 1'b1;
                if (bus.start) begin
                    state_n = S_SHIFT;
                    pat_n   = bus.pattern;
                    shreg_n = bus.pattern;
                    x_n     = bus.pattern[PATTERN_W-1];
                    tick_n  = 1'b1;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            S_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (idx != BIT_LAST) begin
                        idx_n   = idx + IW'(1);
                        shreg_n = shifted;
                        x_n     = shifted[PATTERN_W-1];
                        tick_n  = 1'b1;
                    end else if (GAP_TICKS > 0) begin
                        state_n = S_GAP;
                        idx_n   = '0;
                        x_n     = 1'b1;
                        tick_n  = 1'b1;
                    end else begin
                        eof = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (idx == GAP_LAST) eof = 1'b1;
                    else idx_n = idx + IW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Repeats reload from the latched copy, never from the live port
        if (eof) begin
            idx_n = '0;
            if (bus.repeat_en) begin
                state_n = S_SHIFT;
                shreg_n = pat_q;
                x_n     = pat_q[PATTERN_W-1];
                tick_n  = 1'b1;
            end else begin
                state_n = S_IDLE;
                x_n     = 1'b1;
                done_n  = 1'b1;
            end
        end
    end

    assign bus.x_out    = x_q;
    assign bus.bit_tick = tick_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_q;

`ifdef SEQGEN_SEG_EN
    logic [6:0] seg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) seg_q <= 7'b1001111;
        else     seg_q <= x_n ? 7'b1001111 : 7'b0000001;
    end

    assign {a, b, c, d, e, f, g} = seg_q;
`endif
endmodule

// File: tb/tb_serial_pattern_gen.sv
// Randomized bench for serial_pattern_gen against a frame-position reference model.
// Two instances: DIV=4/GAP=2 and DIV=1/GAP=0, sharing stimulus.
module tb_serial_pattern_gen;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] pattern = '0;
    logic         repeat_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_pattern_gen_if #(.PATTERN_W(W)) sif0 ();
    serial_pattern_gen_if #(.PATTERN_W(W)) sif1 ();

    assign sif0.start     = start;
    assign sif0.pattern   = pattern;
    assign sif0.repeat_en = repeat_en;
    assign sif1.start     = start;
    assign sif1.pattern   = pattern;
    assign sif1.repeat_en = repeat_en;

`ifdef SEQGEN_SEG_EN
    logic [6:0] seg0, seg1;
`endif

    serial_pattern_gen #(
        .PATTERN_W(W), .DIV(4), .GAP_TICKS(2)
    ) u_dut0 (
        .clk(clk),
        .rst(rst),
`ifdef SEQGEN_SEG_EN
        .a(seg0[6]), .b(seg0[5]), .c(seg0[4]), .d(seg0[3]),
        .e(seg0[2]), .f(seg0[1]), .g(seg0[0]),
`endif
        .bus(sif0.slave)
    );

    serial_pattern_gen #(
        .PATTERN_W(W), .DIV(1), .GAP_TICKS(0)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
`ifdef SEQGEN_SEG_EN
        .a(seg1[6]), .b(seg1[5]), .c(seg1[4]), .d(seg1[3]),
        .e(seg1[2]), .f(seg1[1]), .g(seg1[0]),
`endif
        .bus(sif1.slave)
    );

    // Model: a frame is a timeline of (W+GAP)*DIV cycles indexed by position
    int           m_div [2] = '{4, 1};
    int           m_gap [2] = '{2, 0};
    logic         m_act [2];
    int           m_pos [2];
    logic [W-1:0] m_pat [2];
    logic         m_done[2];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k]  <= 1'b0;
                m_pos[k]  <= 0;
                m_pat[k]  <= '0;
                m_done[k] <= 1'b0;
            end else if (!m_act[k]) begin
                m_done[k] <= 1'b0;
                if (start) begin
                    m_act[k] <= 1'b1;
                    m_pos[k] <= 0;
                    m_pat[k] <= pattern;
                end
            end else if (m_pos[k] == (W + m_gap[k]) * m_div[k] - 1) begin
                m_pos[k] <= 0;
                if (!repeat_en) begin
                    m_act[k]  <= 1'b0;
                    m_done[k] <= 1'b1;
                end
            end else begin
                m_pos[k] <= m_pos[k] + 1;
            end
        end
    end

    function automatic logic exp_x(int k);
        logic [W-1:0] p;
        p = m_pat[k];
        if (m_act[k] && m_pos[k] < W * m_div[k])
            return p[W - 1 - m_pos[k] / m_div[k]];
        return 1'b1;
    endfunction

    function automatic logic exp_tick(int k);
        return m_act[k] && (m_pos[k] % m_div[k] == 0)
            && (m_pos[k] <= W * m_div[k]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_model;
        chk("x0",    32'(sif0.x_out),    32'(exp_x(0)));
        chk("tick0", 32'(sif0.bit_tick), 32'(exp_tick(0)));
        chk("busy0", 32'(sif0.busy),     32'(m_act[0]));
        chk("done0", 32'(sif0.done),     32'(m_done[0]));
        chk("x1",    32'(sif1.x_out),    32'(exp_x(1)));
        chk("tick1", 32'(sif1.bit_tick), 32'(exp_tick(1)));
        chk("busy1", 32'(sif1.busy),     32'(m_act[1]));
        chk("done1", 32'(sif1.done),     32'(m_done[1]));
`ifdef SEQGEN_SEG_EN
        chk("seg0", 32'(seg0), exp_x(0) ? 32'h4f : 32'h01);
        chk("seg1", 32'(seg1), exp_x(1) ? 32'h4f : 32'h01);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_x"},    32'({sif0.x_out, sif1.x_out}), 32'h3);
        chk({tag, "_busy"}, 32'({sif0.busy, sif1.busy}), 32'h0);
        chk({tag, "_tick"}, 32'({sif0.bit_tick, sif1.bit_tick}), 32'h0);
        chk({tag, "_done"}, 32'({sif0.done, sif1.done}), 32'h0);
`ifdef SEQGEN_SEG_EN
        chk({tag, "_seg"}, 32'({seg0, seg1}), 32'h27cf);
`endif
    endtask

    int accept_cyc;
    int done_cyc;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;

        // Directed frame 0001_0001 with an ignored FF start mid-frame
        @(negedge clk);
        check_model();
        start   = 1'b1;
        pattern = 8'b0001_0001;
        accept_cyc = 0;
        done_cyc   = -1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            check_model();
            start   = (c == 10);
            pattern = (c == 10) ? 8'hFF : 8'h00;
            if (sif0.done && done_cyc < 0) done_cyc = c;
        end
        chk("done_cycle", 32'(done_cyc), 32'd41);

        // Mid-bit reset: outputs must drop immediately
        start   = 1'b1;
        pattern = 8'hA5;
        @(negedge clk);
        check_model();
        start = 1'b0;
        repeat (16) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("midrst");
        @(negedge clk);
        check_model();
        rst = 1'b0;

        // Randomized phase with occasional async resets and held starts
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            check_model();
            if (rst) rst = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 check_reset_state("rndrst");
            end
            start   = ($urandom_range(0, 5) == 0) || (c % 700 < 60);
            pattern = W'($urandom);
            if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
        end

        @(negedge clk);
        check_model();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
